// File: rtl/cmul_arb_pkg.sv
// Shared definitions for the cmul_share_arb slice: default sizes, the requester-ID
// width helper, the tag type carried alongside each multiplier issue, and the
// round-robin pointer reset value.
package cmul_arb_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefNReq  = 4;
  // Widest requester ID needed for the largest legal N_REQ (16).
  localparam int unsigned MaxIdw   = 4;

  function automatic int unsigned id_width(int unsigned n_req);
    return (n_req < 2) ? 1 : $clog2(n_req);
  endfunction

  // Pointer starts at the last requester so requester 0 is searched first.
  function automatic int unsigned rst_ptr(int unsigned n_req);
    return n_req - 1;
  endfunction

  typedef struct packed {
    logic              valid;
    logic [MaxIdw-1:0] id;
  } tag_t;

endpackage

// File: rtl/cmul_share_arb_if.sv
// Request, multiplier and response signals of cmul_share_arb.
//   master: requesters + multiplier side (drives requests and mul_result)
//   slave : the scheduler (drives grants, operands and responses)
interface cmul_share_arb_if
  import cmul_arb_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned N_REQ = DefNReq,
  parameter int unsigned IDW   = id_width(N_REQ)
);

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ*WIDTH-1:0] req_a;
  logic [N_REQ*WIDTH-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;
  logic [WIDTH-1:0]       mul_a;
  logic [WIDTH-1:0]       mul_b;
  logic [2*WIDTH-1:0]     mul_result;
  logic                   rsp_valid;
  logic [IDW-1:0]         rsp_id;
  logic [2*WIDTH-1:0]     rsp_data;

  modport master (
    output req_valid, req_a, req_b, mul_result,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, mul_result,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_id, rsp_data
  );

endinterface

// File: rtl/cmul_rr_arb.sv
// Round-robin picker for cmul_share_arb. Owns the RR pointer.
//   clk, rst_n : clock, async active-low reset
//   req_valid  : request vector
//   enable     : gates all grants
//   xfer       : a grant was accepted this cycle (pointer advances)
//   grant      : one-hot grant (combinational)
//   grant_id   : index of the picked requester
// Optional macro CMUL_ARB_PRIO0_EN: requester 0 wins whenever valid and does not
// move the pointer; the others stay round-robin.
module cmul_rr_arb
  import cmul_arb_pkg::*;
#(
  parameter int unsigned N_REQ = DefNReq,
  parameter int unsigned IDW   = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_valid,
  input  logic             enable,
  input  logic             xfer,
  output logic [N_REQ-1:0] grant,
  output logic [IDW-1:0]   grant_id
);

  localparam logic [IDW-1:0] PtrRst = IDW'(rst_ptr(N_REQ));

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] idx;
  logic           found;

  // Search from ptr+1 upward, wrapping; first valid requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = '0;
`ifdef CMUL_ARB_PRIO0_EN
    if (req_valid[0]) begin
      found = 1'b1;
    end
`endif
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = IDW'((32'(ptr_q) + k) % N_REQ);
      if (!found && req_valid[idx]) begin
        found    = 1'b1;
        grant_id = idx;
      end
    end
    if (enable && found) begin
      grant[grant_id] = 1'b1;
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (xfer) begin
      ptr_d = grant_id;
    end
`ifdef CMUL_ARB_PRIO0_EN
    // A grant to requester 0 is always a priority grant.
    if (xfer && grant_id == '0) begin
      ptr_d = ptr_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= PtrRst;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/cmul_share_arb.sv
// Shares one pipelined complex multiplier among N_REQ requesters.
// Grants round-robin, registers the winner's operands into the multiplier, tracks
// each issue through MUL_LAT cycles with a tag pipeline and returns the product
// tagged with the requester ID. No backpressure anywhere downstream.
//   clk, rst_n : clock, async active-low reset
//   enable     : allows new grants; in-flight work always drains
//   idle       : no tag in flight
//   bus        : request / multiplier / response signals (slave modport)
// Optional macro CMUL_ARB_PRIO0_EN: fixed priority for requester 0 (see cmul_rr_arb).
module cmul_share_arb
  import cmul_arb_pkg::*;
#(
  parameter int unsigned WIDTH   = DefWidth,
  parameter int unsigned N_REQ   = DefNReq,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned IDW     = id_width(N_REQ)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  output logic             idle,
  cmul_share_arb_if.slave  bus
);

  logic [N_REQ-1:0]   grant;
  logic [IDW-1:0]     grant_id;
  logic               xfer;
  logic [WIDTH-1:0]   win_a, win_b;
  logic [WIDTH-1:0]   mul_a_q, mul_b_q;
  logic               rsp_valid_q;
  logic [IDW-1:0]     rsp_id_q;
  logic [2*WIDTH-1:0] rsp_data_q;

  // Stage k holds the issue made k+1 edges ago; stage MUL_LAT lines up with mul_result.
  tag_t tag_q [MUL_LAT+1];

  cmul_rr_arb #(
    .N_REQ (N_REQ),
    .IDW   (IDW)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (bus.req_valid),
    .enable    (enable),
    .xfer      (xfer),
    .grant     (grant),
    .grant_id  (grant_id)
  );

  assign bus.req_ready = grant;
  assign xfer          = |(bus.req_valid & grant);

  always_comb begin
    win_a = '0;
    win_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        win_a = bus.req_a[i*WIDTH +: WIDTH];
        win_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      for (int unsigned k = 0; k <= MUL_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      if (xfer) begin
        mul_a_q <= win_a;
        mul_b_q <= win_b;
      end
      tag_q[0] <= '{valid: xfer, id: MaxIdw'(grant_id)};
      for (int unsigned k = 1; k <= MUL_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      rsp_valid_q <= tag_q[MUL_LAT].valid;
      // Response fields hold between products.
      if (tag_q[MUL_LAT].valid) begin
        rsp_id_q   <= tag_q[MUL_LAT].id[IDW-1:0];
        rsp_data_q <= bus.mul_result;
      end
    end
  end

  always_comb begin
    idle = 1'b1;
    for (int unsigned k = 0; k <= MUL_LAT; k++) begin
      if (tag_q[k].valid) begin
        idle = 1'b0;
      end
    end
  end

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_cmul_share_arb.sv
// Bench for cmul_share_arb: behavioural multiplier, queue-based reference model
// checked every falling edge, plus directed scenarios with literal expectations.
module tb_cmul_share_arb;
  import cmul_arb_pkg::*;

  localparam int unsigned W   = 32;
  localparam int unsigned H   = W / 2;
  localparam int unsigned N   = 4;
  localparam int unsigned L   = 2;
  localparam int unsigned IDW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic idle;

  cmul_share_arb_if #(.WIDTH(W), .N_REQ(N), .IDW(IDW)) bus ();

  cmul_share_arb #(
    .WIDTH   (W),
    .N_REQ   (N),
    .MUL_LAT (L),
    .IDW     (IDW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (enable),
    .idle   (idle),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Complex product of signed 16-bit halves, each part modulo 2^W.
  function automatic logic [2*W-1:0] cmul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] ar, ai, br, bi, re, im;
    ar = W'(signed'(a[H-1:0]));
    ai = W'(signed'(a[W-1:H]));
    br = W'(signed'(b[H-1:0]));
    bi = W'(signed'(b[W-1:H]));
    re = ar * br - ai * bi;
    im = ar * bi + ai * br;
    return {re, im};
  endfunction

  // Behavioural multiplier with L cycles of latency.
  logic [2*W-1:0] mpipe [L];
  always @(posedge clk) begin
    mpipe[0] <= cmul(bus.mul_a, bus.mul_b);
    for (int k = 1; k < L; k++) mpipe[k] <= mpipe[k-1];
  end
  assign bus.mul_result = mpipe[L-1];

  // ---------------- reference model ----------------
  typedef struct {
    int             due;
    int             id;
    logic [2*W-1:0] prod;
  } pend_t;

  pend_t          pq[$];
  int             m_ptr = N - 1;
  int             ncnt = 0;
  int             w;
  logic [N-1:0]   eg;
  logic [W-1:0]   e_mul_a = '0, e_mul_b = '0, ta, tb;
  logic           e_rv = 1'b0;
  logic [IDW-1:0] e_rid = '0;
  logic [2*W-1:0] e_rdata = '0;

  function automatic int model_pick(input logic [N-1:0] rv, input int ptr);
`ifdef CMUL_ARB_PRIO0_EN
    if (rv[0]) return 0;
`endif
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (ptr + k) % N;
      if (rv[IDW'(j)]) return j;
    end
    return -1;
  endfunction

  always @(negedge clk) begin
    ncnt++;
    if (!rst_n) begin
      pq.delete();
      m_ptr   = N - 1;
      e_mul_a = '0;
      e_mul_b = '0;
      e_rv    = 1'b0;
      e_rid   = '0;
      e_rdata = '0;
    end else begin
      e_rv = 1'b0;
      if (pq.size() > 0 && pq[0].due == ncnt) begin
        e_rv    = 1'b1;
        e_rid   = IDW'(pq[0].id);
        e_rdata = pq[0].prod;
        void'(pq.pop_front());
      end
    end
    chk("m_rsp_valid", 64'(bus.rsp_valid), 64'(e_rv));
    chk("m_rsp_id", 64'(bus.rsp_id), 64'(e_rid));
    chk("m_rsp_data", bus.rsp_data, e_rdata);
    chk("m_mul_a", 64'(bus.mul_a), 64'(e_mul_a));
    chk("m_mul_b", 64'(bus.mul_b), 64'(e_mul_b));
    chk("m_idle", 64'(idle), 64'(pq.size() == 0));
    // Grant that the coming rising edge will see.
    w  = model_pick(bus.req_valid, m_ptr);
    eg = '0;
    if (enable && w >= 0) eg[IDW'(w)] = 1'b1;
    chk("m_req_ready", 64'(bus.req_ready), 64'(eg));
    if (rst_n && enable && w >= 0) begin
      ta = bus.req_a[w*W +: W];
      tb = bus.req_b[w*W +: W];
      pq.push_back('{due: ncnt + L + 2, id: w, prod: cmul(ta, tb)});
      e_mul_a = ta;
      e_mul_b = tb;
`ifdef CMUL_ARB_PRIO0_EN
      if (w != 0) m_ptr = w;
`else
      m_ptr = w;
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int             seen;
  logic [2*W-1:0] got_data;
  logic [IDW-1:0] got_id;
  logic [N-1:0]   exp_rr;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
    chk("reset_idle", 64'(idle), 64'd1);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_mul_a", 64'(bus.mul_a), 64'd0);
    chk("reset_rsp_data", bus.rsp_data, 64'd0);

    // All requesters valid: grants rotate 0,1,2,3,...
    for (int i = 0; i < N; i++) begin
      bus.req_a[i*W +: W] = {16'(i * 7 + 1), 16'(i + 3)};
      bus.req_b[i*W +: W] = {16'(i + 2), 16'(2 * i + 5)};
    end
    enable        = 1'b1;
    bus.req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      #1;
`ifdef CMUL_ARB_PRIO0_EN
      exp_rr = 4'b0001;
`else
      exp_rr = 4'b0001 << (c % 4);
`endif
      chk("rr_grant", 64'(bus.req_ready), 64'(exp_rr));
      if (c >= 4) begin
        chk("rr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
`ifdef CMUL_ARB_PRIO0_EN
        chk("rr_rsp_id", 64'(bus.rsp_id), 64'd0);
`else
        chk("rr_rsp_id", 64'(bus.rsp_id), 64'((c - 4) % 4));
`endif
      end
      step();
    end
    bus.req_valid = '0;
    repeat (L + 3) step();
    chk("rr_drain_idle", 64'(idle), 64'd1);

    // Requester 2 alone with a known product.
    bus.req_a[2*W +: W] = 32'h0002_0003;
    bus.req_b[2*W +: W] = 32'h0004_0005;
    bus.req_valid = 4'b0100;
    step();
    bus.req_valid = '0;
    seen = 0;
    got_data = '0;
    got_id = '0;
    for (int c = 0; c < 10; c++) begin
      if (bus.rsp_valid) begin
        seen++;
        got_data = bus.rsp_data;
        got_id   = bus.rsp_id;
      end
      step();
    end
    chk("single_pulses", 64'(seen), 64'd1);
    chk("single_data", got_data, 64'h00000007_00000016);
    chk("single_id", 64'(got_id), 64'd2);

    // Two grants, then enable dropped while requests stay valid.
    bus.req_valid = '1;
    step();
    step();
    enable = 1'b0;
    #1;
    chk("en_off_ready", 64'(bus.req_ready), 64'd0);
    seen = 0;
    for (int c = 0; c < 8; c++) begin
      if (bus.rsp_valid) seen++;
      step();
    end
    chk("en_off_rsp_count", 64'(seen), 64'd2);
    chk("en_off_idle", 64'(idle), 64'd1);
    bus.req_valid = '0;
    enable = 1'b1;

    // Reset with two tags in flight.
    bus.req_valid = '1;
    step();
    step();
    rst_n = 1'b0;
    bus.req_valid = '0;
    #1;
    chk("rst_mid_mul_a", 64'(bus.mul_a), 64'd0);
    chk("rst_mid_idle", 64'(idle), 64'd1);
    chk("rst_mid_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.rsp_valid) seen++;
      step();
    end
    chk("rst_mid_no_rsp", 64'(seen), 64'd0);
    bus.req_valid = 4'b1010;
    #1;
    chk("post_rst_lowest", 64'(bus.req_ready), 64'(4'b0010));
    step();

    // Pointer at 1 with requesters 1 and 3: grant 3 then 1.
    #1;
    chk("rr13_first", 64'(bus.req_ready), 64'(4'b1000));
    step();
    #1;
    chk("rr13_second", 64'(bus.req_ready), 64'(4'b0010));
    step();
    // Withdrawal before the edge: no transfer, pointer stays at 1.
    bus.req_valid = 4'b0010;
    #1;
    chk("withdraw_ready", 64'(bus.req_ready), 64'(4'b0010));
    #1;
    bus.req_valid = '0;
    #1;
    chk("withdraw_dropped", 64'(bus.req_ready), 64'd0);
    step();
    bus.req_valid = 4'b1010;
    #1;
    chk("withdraw_ptr_held", 64'(bus.req_ready), 64'(4'b1000));
    step();
    bus.req_valid = '0;

`ifdef CMUL_ARB_PRIO0_EN
    // Requester 0 always wins; then 1 and 2 share round-robin.
    bus.req_valid = 4'b0111;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("prio0_grant", 64'(bus.req_ready), 64'(4'b0001));
      step();
    end
    bus.req_valid = 4'b0110;
    #1;
    chk("prio0_after_1", 64'(bus.req_ready), 64'(4'b0010));
    step();
    #1;
    chk("prio0_after_2", 64'(bus.req_ready), 64'(4'b0100));
    step();
    bus.req_valid = '0;
`endif

    repeat (L + 4) step();
    chk("final_idle", 64'(idle), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
